// File: rtl/gb_cpu_pkg.sv
// Shared CPU constants: 8-bit register indices, pair indices,
// flag bit positions and the pair-to-byte mapping used by the regfile.
package gb_cpu_pkg;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_F = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;

    localparam logic [1:0] PAIR_BC = 2'd0;
    localparam logic [1:0] PAIR_DE = 2'd1;
    localparam logic [1:0] PAIR_HL = 2'd2;
    localparam logic [1:0] PAIR_SP = 2'd3;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Byte storage: 0..7 follow the 8-bit index, 8 = SPh, 9 = SPl
    localparam int NREGS   = 10;
    localparam int IDX_F   = 6;
    localparam int IDX_SPH = 8;
    localparam int IDX_SPL = 9;

    // Bytes that hold the high half of their pair (B, D, H, SPh)
    localparam logic [NREGS-1:0] HI_BYTES = 10'b01_0001_0101;

    function automatic logic [NREGS-1:0] pair_mask(
        input logic [1:0] p
    );
        case (p)
            PAIR_BC: pair_mask = 10'b00_0000_0011;
            PAIR_DE: pair_mask = 10'b00_0000_1100;
            PAIR_HL: pair_mask = 10'b00_0011_0000;
            default: pair_mask = 10'b11_0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/singlereg.sv
// One 8-bit register with write enable and async active-high reset.
// Ports: clk, rst, we, d[7:0] in; q[7:0] out.
module singlereg #(
    parameter logic [7:0] RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST;
        else if (we)
            q <= d;
    end

endmodule

// File: rtl/gb_regfile.sv
// Game Boy register file: B..A, F, SP with IDU and masked flag update.
// Ports: rd_a/rd_b/rd16 reads, wr8/wr16 writes, idu_*, flag_*, flags.
module gb_regfile
    import gb_cpu_pkg::*;
#(
    parameter logic [15:0] SP_RST    = 16'h0000,
    parameter bit          F_ZEROMSK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd_a_sel,
    output logic [7:0]  rd_a,
    input  logic [2:0]  rd_b_sel,
    output logic [7:0]  rd_b,
    input  logic [1:0]  rd16_sel,
    output logic [15:0] rd16,
    input  logic [2:0]  wr8_sel,
    input  logic [7:0]  wr8_data,
    input  logic        wr8_we,
    input  logic [1:0]  wr16_sel,
    input  logic [15:0] wr16_data,
    input  logic        wr16_we,
    input  logic [1:0]  idu_sel,
    input  logic        idu_dec,
    input  logic        idu_en,
    output logic [15:0] idu_out,
    input  logic [3:0]  flag_in,
    input  logic [3:0]  flag_mask,
    input  logic        flag_we,
    output logic [3:0]  flags
);

    localparam logic [7:0] FMSK = F_ZEROMSK ? 8'hF0 : 8'hFF;

    logic [7:0]       q [NREGS];
    logic [7:0]       d [NREGS];
    logic [NREGS-1:0] we;
    logic [NREGS-1:0] m8;
    logic [NREGS-1:0] m16;
    logic [NREGS-1:0] midu;
    logic [7:0]       fq;
    logic [15:0]      idu_src;
    logic [3:0]       fnew;

    function automatic logic [15:0] pair_rd(
        input logic [1:0] p
    );
        case (p)
            PAIR_BC: pair_rd = {q[0], q[1]};
            PAIR_DE: pair_rd = {q[2], q[3]};
            PAIR_HL: pair_rd = {q[4], q[5]};
            default: pair_rd = {q[IDX_SPH], q[IDX_SPL]};
        endcase
    endfunction

    assign m8   = wr8_we  ? (10'd1 << wr8_sel) : '0;
    assign m16  = wr16_we ? pair_mask(wr16_sel) : '0;
    assign midu = idu_en  ? pair_mask(idu_sel) : '0;

    assign fq    = q[IDX_F] & FMSK;
    assign flags = q[IDX_F][7:4];
    assign fnew  = (q[IDX_F][7:4] & ~flag_mask)
                 | (flag_in & flag_mask);

    always_comb begin
        rd_a = (rd_a_sel == REG_F) ? fq : q[{1'b0, rd_a_sel}];
        rd_b = (rd_b_sel == REG_F) ? fq : q[{1'b0, rd_b_sel}];
        rd16 = pair_rd(rd16_sel);
    end

    // Decrement adds all-ones; increment adds zero with carry-in.
    assign idu_src = pair_rd(idu_sel);
    assign idu_out = idu_src
                   + {16{idu_dec}}
                   + {15'd0, ~idu_dec};

    // Per-byte priority: wr8 > wr16 > idu > flag update.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            we[i] = m8[i] | m16[i] | midu[i];
            d[i]  = q[i];
            if (m8[i])
                d[i] = wr8_data;
            else if (m16[i])
                d[i] = HI_BYTES[i] ? wr16_data[15:8]
                                   : wr16_data[7:0];
            else if (midu[i])
                d[i] = HI_BYTES[i] ? idu_out[15:8]
                                   : idu_out[7:0];
        end
        if (flag_we && !m8[IDX_F]) begin
            we[IDX_F] = 1'b1;
            d[IDX_F]  = {fnew, q[IDX_F][3:0]};
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        localparam logic [7:0] RV =
            (g == IDX_SPH) ? SP_RST[15:8] :
            (g == IDX_SPL) ? SP_RST[7:0]  : 8'h00;
        localparam logic [7:0] WM =
            (g == IDX_F) ? FMSK : 8'hFF;
        singlereg #(.RST(RV)) u_reg (
            .clk (clk),
            .rst (rst),
            .we  (we[g]),
            .d   (d[g] & WM),
            .q   (q[g])
        );
    end

    assert property (@(posedge clk) disable iff (rst)
        !$isunknown({wr8_we, wr16_we, idu_en, flag_we}));

endmodule
